// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit RISC core control path.
package cpu_pkg;

    // Control FSM states.
    typedef enum logic [3:0] {
        RST,
        IF1,
        UPDATE_PC,
        DECODE,
        GETA,
        GETB,
        EXEC,
        EXEC_S,
        EXEC_P,
        LD_ADDR,
        MEM_RD,
        MEM_WR,
        WRITE_REG,
        HALT
    } state_t;

    // Memory command encodings.
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // Instruction class opcodes (IR[15:13]).
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Sub-operation codes (IR[12:11]).
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;
    localparam logic [1:0] MEM_OP  = 2'b00;

    // First state after DECODE for a given instruction; HALT for halt and
    // for undecodable codes (the caller distinguishes those two).
    function automatic state_t decode_target(input logic [2:0] opc, input logic [1:0] sub);
        state_t nxt;
        nxt = HALT;
        case (opc)
            OP_MOV: begin
                if (sub == MOV_IMM)      nxt = WRITE_REG;
                else if (sub == MOV_REG) nxt = GETB;
                else                     nxt = HALT;
            end
            OP_ALU:  nxt = (sub == ALU_MVN) ? GETB : GETA;
            OP_LDR:  nxt = (sub == MEM_OP) ? GETA : HALT;
            OP_STR:  nxt = (sub == MEM_OP) ? GETA : HALT;
            default: nxt = HALT;
        endcase
        return nxt;
    endfunction

    // True when {opcode, op} names a real instruction (including HALT).
    function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] sub);
        return (opc == OP_HALT) || (decode_target(opc, sub) != HALT);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: fetch, PC update, operand read, execute,
// writeback and data-memory access strobes for the 16-bit RISC datapath.
module cpu_controller #(
    parameter int MEM_CMD_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           opcode,
    input  logic [1:0]           op,
    input  logic                 mem_ack,
    output logic                 load_ir,
    output logic                 load_pc,
    output logic                 reset_pc,
    output logic                 addr_sel,
    output logic                 load_addr,
    output logic [MEM_CMD_W-1:0] mem_cmd,
    output logic                 loada,
    output logic                 loadb,
    output logic                 loadc,
    output logic                 loads,
    output logic                 write,
    output logic                 pass_b,
    output logic                 halted,
    output logic                 illegal
);
    import cpu_pkg::*;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [1:0] cmd;

    // Next-state and strobe decode; strobes are Moore on state except the
    // memory-state acknowledgements, which qualify load_ir and the exit.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        cmd       = MEM_NONE;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        pass_b    = 1'b0;
        halted    = 1'b0;

        case (state_q)
            RST: begin
                // While reset is still held the PC strobes must stay quiet.
                reset_pc = !reset;
                load_pc  = !reset;
                state_d  = IF1;
            end
            IF1: begin
                addr_sel = 1'b1;
                cmd      = MEM_READ;
                if (mem_ack) begin
                    load_ir = 1'b1;
                    state_d = UPDATE_PC;
                end
            end
            UPDATE_PC: begin
                load_pc = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = decode_target(opcode, op);
                if (!is_legal(opcode, op)) begin
                    illegal_d = 1'b1;
                end
            end
            GETA: begin
                loada   = 1'b1;
                // Two-operand ALU ops fetch B next; LDR/STR go straight to
                // address generation from A.
                state_d = (opcode == OP_ALU) ? GETB : EXEC;
            end
            GETB: begin
                loadb = 1'b1;
                if ((opcode == OP_ALU) && (op == ALU_CMP)) begin
                    state_d = EXEC_S;
                end else if (opcode == OP_STR) begin
                    state_d = EXEC_P;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                loadc   = 1'b1;
                state_d = ((opcode == OP_LDR) || (opcode == OP_STR)) ? LD_ADDR : WRITE_REG;
            end
            EXEC_S: begin
                loads   = 1'b1;
                state_d = IF1;
            end
            EXEC_P: begin
                // Store data travels through the ALU as 0 + B.
                loadc   = 1'b1;
                pass_b  = 1'b1;
                state_d = MEM_WR;
            end
            LD_ADDR: begin
                load_addr = 1'b1;
                // STR still needs its data operand after the address is held.
                state_d   = (opcode == OP_STR) ? GETB : MEM_RD;
            end
            MEM_RD: begin
                cmd = MEM_READ;
                if (mem_ack) begin
                    state_d = WRITE_REG;
                end
            end
            MEM_WR: begin
                cmd = MEM_WRITE;
                if (mem_ack) begin
                    state_d = IF1;
                end
            end
            WRITE_REG: begin
                write   = 1'b1;
                state_d = IF1;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    assign mem_cmd = MEM_CMD_W'(cmd);
    assign illegal = illegal_q;

    // State and sticky illegal flag; reset returns to RST at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RST;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: latency table, directed corner
// sequences and randomized instruction streams against a recipe model.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       mem_ack = 1'b0;

    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       loada, loadb, loadc, loads, write, pass_b, halted, illegal;

    always #5 clk = ~clk;

    cpu_controller #(.MEM_CMD_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .op        (op),
        .mem_ack   (mem_ack),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .addr_sel  (addr_sel),
        .load_addr (load_addr),
        .mem_cmd   (mem_cmd),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .write     (write),
        .pass_b    (pass_b),
        .halted    (halted),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       pass_b;
        logic       halted;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [2:0] opc;
        logic [1:0] sub;
        int         lat;
        int         writes;
        int         flag_loads;
        logic       halt;
        logic       ill;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic  q_ack[$];
    obs_t  q_exp[$];
    string q_tag[$];

    function automatic obs_t sample();
        obs_t s;
        s.load_ir   = load_ir;
        s.load_pc   = load_pc;
        s.reset_pc  = reset_pc;
        s.addr_sel  = addr_sel;
        s.load_addr = load_addr;
        s.mem_cmd   = mem_cmd;
        s.loada     = loada;
        s.loadb     = loadb;
        s.loadc     = loadc;
        s.loads     = loads;
        s.write     = write;
        s.pass_b    = pass_b;
        s.halted    = halted;
        s.illegal   = illegal;
        return s;
    endfunction

    task automatic check(input obs_t exp, input string tag);
        obs_t got;
        got = sample();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (ir pc rpc asel ladr cmd2 a b c s wr pb hlt ill)",
                     tag, got, exp);
        end
        else $display("ok   %s: %h", tag, got);
    endtask

    task automatic cmp_int(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
        else $display("ok   %s: %0d", tag, got);
    endtask

    // One clock cycle: drive ack on the falling edge, sample 1 ns later.
    task automatic step(input logic ack, input obs_t exp, input string tag);
        @(negedge clk);
        mem_ack = ack;
        #1;
        check(exp, tag);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int pick(input int fixed);
        return (fixed >= 0) ? fixed : int'($urandom_range(0, 3));
    endfunction

    // Micro-op recipe per instruction: A=read A, B=read B, X=execute,
    // S=set flags, P=pass B, L=latch address, R=memory read, M=memory write,
    // W=register writeback. Empty string means the core stops.
    function automatic string recipe(input logic [2:0] opc, input logic [1:0] sub);
        case ({opc, sub})
            5'b110_10: return "W";
            5'b110_00: return "BXW";
            5'b101_00: return "ABXW";
            5'b101_10: return "ABXW";
            5'b101_01: return "ABS";
            5'b101_11: return "BXW";
            5'b011_00: return "AXLRW";
            5'b100_00: return "AXLBPM";
            default:   return "";
        endcase
    endfunction

    task automatic push(input logic ack, input obs_t e, input string tag);
        q_ack.push_back(ack);
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    // Expand one instruction into expected per-cycle observations.
    task automatic model_instr(input logic [2:0] opc, input logic [1:0] sub,
                               input int fetch_wait, input int mem_wait, input int halt_hold);
        obs_t  e;
        string r;
        int    w;
        byte   c;
        r = recipe(opc, sub);
        w = pick(fetch_wait);
        for (int i = 0; i < w; i++) begin
            e = '0; e.addr_sel = 1'b1; e.mem_cmd = 2'b01;
            push(1'b0, e, "fetch_wait");
        end
        e = '0; e.addr_sel = 1'b1; e.mem_cmd = 2'b01; e.load_ir = 1'b1;
        push(1'b1, e, "fetch_ack");
        e = '0; e.load_pc = 1'b1;
        push(rnd_bit(), e, "pc_inc");
        e = '0;
        push(rnd_bit(), e, "decode");
        if (r.len() == 0) begin
            for (int i = 0; i < halt_hold; i++) begin
                e = '0; e.halted = 1'b1; e.illegal = (opc != 3'b111);
                push(rnd_bit(), e, "halt");
            end
        end else begin
            for (int k = 0; k < r.len(); k++) begin
                c = r[k];
                e = '0;
                case (c)
                    "A": begin e.loada = 1'b1; push(rnd_bit(), e, "geta"); end
                    "B": begin e.loadb = 1'b1; push(rnd_bit(), e, "getb"); end
                    "X": begin e.loadc = 1'b1; push(rnd_bit(), e, "exec"); end
                    "S": begin e.loads = 1'b1; push(rnd_bit(), e, "exec_s"); end
                    "P": begin e.loadc = 1'b1; e.pass_b = 1'b1; push(rnd_bit(), e, "exec_p"); end
                    "L": begin e.load_addr = 1'b1; push(rnd_bit(), e, "ld_addr"); end
                    "W": begin e.write = 1'b1; push(rnd_bit(), e, "write_reg"); end
                    "R", "M": begin
                        e.mem_cmd = (c == "R") ? 2'b01 : 2'b10;
                        w = pick(mem_wait);
                        for (int i = 0; i < w; i++) push(1'b0, e, "mem_wait");
                        push(1'b1, e, "mem_ack");
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic run_queue();
        while (q_exp.size() > 0) begin
            step(q_ack.pop_front(), q_exp.pop_front(), q_tag.pop_front());
        end
    endtask

    task automatic do_instr(input logic [2:0] opc, input logic [1:0] sub,
                            input int fetch_wait, input int mem_wait, input int halt_hold);
        opcode = opc;
        op     = sub;
        model_instr(opc, sub, fetch_wait, mem_wait, halt_hold);
        run_queue();
    endtask

    // Release reset between edges, then check the PC-reset cycle.
    task automatic release_reset();
        obs_t e;
        @(posedge clk);
        #2 reset = 1'b0;
        e = '0; e.reset_pc = 1'b1; e.load_pc = 1'b1;
        step(rnd_bit(), e, "rst_cycle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        mem_ack = 1'b0;
        #1;
        check('0, "in_reset");
        release_reset();
    endtask

    // Zero-wait run from reset; measures cycles from IF1 to next IF1 or HALT.
    task automatic run_table_entry(input vec_t v, input int idx);
        int   cyc, n_wr, n_ld;
        logic done, saw_halt, ill;
        do_reset();
        opcode = v.opc;
        op     = v.sub;
        cyc = 0; n_wr = 0; n_ld = 0;
        done = 1'b0; saw_halt = 1'b0; ill = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            mem_ack = 1'b1;
            #1;
            if (cyc > 0 && addr_sel && mem_cmd == 2'b01) begin
                done = 1'b1;
            end else if (halted) begin
                done = 1'b1; saw_halt = 1'b1; ill = illegal;
            end else begin
                n_wr += int'(write);
                n_ld += int'(loads);
                cyc++;
            end
        end
        cmp_int($sformatf("tbl%0d_finished", idx), int'(done), 1);
        cmp_int($sformatf("tbl%0d_latency", idx), cyc, v.lat);
        cmp_int($sformatf("tbl%0d_writes", idx), n_wr, v.writes);
        cmp_int($sformatf("tbl%0d_loads", idx), n_ld, v.flag_loads);
        cmp_int($sformatf("tbl%0d_halted", idx), int'(saw_halt), int'(v.halt));
        cmp_int($sformatf("tbl%0d_illegal", idx), int'(ill), int'(v.ill));
    endtask

    logic [4:0] legal_codes [8] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_10,
                                    5'b101_01, 5'b101_11, 5'b011_00, 5'b100_00};

    initial begin
        vec_t tbl[13];
        logic [4:0] code;

        // CMP finishes in EXEC_S with no writeback cycle: 3 fetch/decode + A, B, S.
        tbl[0]  = '{3'b110, 2'b10, 4, 1, 0, 1'b0, 1'b0};
        tbl[1]  = '{3'b110, 2'b00, 6, 1, 0, 1'b0, 1'b0};
        tbl[2]  = '{3'b101, 2'b00, 7, 1, 0, 1'b0, 1'b0};
        tbl[3]  = '{3'b101, 2'b10, 7, 1, 0, 1'b0, 1'b0};
        tbl[4]  = '{3'b101, 2'b01, 6, 0, 1, 1'b0, 1'b0};
        tbl[5]  = '{3'b101, 2'b11, 6, 1, 0, 1'b0, 1'b0};
        tbl[6]  = '{3'b011, 2'b00, 8, 1, 0, 1'b0, 1'b0};
        tbl[7]  = '{3'b100, 2'b00, 9, 0, 0, 1'b0, 1'b0};
        tbl[8]  = '{3'b111, 2'b01, 3, 0, 0, 1'b1, 1'b0};
        tbl[9]  = '{3'b000, 2'b00, 3, 0, 0, 1'b1, 1'b1};
        tbl[10] = '{3'b110, 2'b01, 3, 0, 0, 1'b1, 1'b1};
        tbl[11] = '{3'b011, 2'b10, 3, 0, 0, 1'b1, 1'b1};
        tbl[12] = '{3'b100, 2'b01, 3, 0, 0, 1'b1, 1'b1};

        #1;
        check('0, "reset_held");

        for (int i = 0; i < 13; i++) run_table_entry(tbl[i], i);

        // Directed: ADD with a 3-cycle fetch wait, LDR with 2-cycle data ack,
        // CMP, STR with a slow write.
        do_reset();
        do_instr(3'b101, 2'b00, 3, 0, 0);
        do_instr(3'b011, 2'b00, 0, 1, 0);
        do_instr(3'b101, 2'b01, 0, 0, 0);
        do_instr(3'b100, 2'b00, 0, 2, 0);

        // Directed: asynchronous reset while MEM_RD waits for its ack.
        do_reset();
        opcode = 3'b011; op = 2'b00;
        model_instr(3'b011, 2'b00, 0, 5, 0);
        for (int i = 0; i < 8; i++) step(q_ack.pop_front(), q_exp.pop_front(), q_tag.pop_front());
        q_ack.delete(); q_exp.delete(); q_tag.delete();
        #1 reset = 1'b1;
        #1 check('0, "async_reset_mid_mem_rd");
        release_reset();

        // Directed: HALT absorbs for many cycles; undecodable code sets illegal.
        do_reset();
        do_instr(3'b111, 2'b10, 0, 0, 25);
        do_reset();
        do_instr(3'b000, 2'b00, 0, 0, 4);

        // Randomized instruction streams with random waits, ending in a stop.
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int k = 0; k < 30; k++) begin
                code = legal_codes[$urandom_range(0, 7)];
                do_instr(code[4:2], code[1:0], -1, -1, 0);
            end
            code = 5'($urandom_range(0, 31));
            while (recipe(code[4:2], code[1:0]).len() != 0) code = 5'($urandom_range(0, 31));
            do_instr(code[4:2], code[1:0], -1, -1, 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
